uart_image_loader: RTL and testbench

//  Sits directly downstream of uart_rcvr. Consumes its byte strobes, packs bytes into pixels and writes

---
 rtl/uart_image_loader.sv | 199 +++++++++++++++++++
 tb/tb_uart_image_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_image_loader.sv
// Packs UART bytes into pixels and writes a frame sequentially; optional checksum stage via UART_IMG_CHECKSUM_EN.
// Latency: pix_we one cycle after the strobe carrying the last byte of a pixel.
// Backpressure: fpga_can_receive drops while a full frame is held; bytes arriving then are dropped and flagged.
module uart_image_loader #(
    parameter int IMG_W          = 320,
    parameter int IMG_H          = 240,
    parameter int PIXEL_BYTES    = 1,
    parameter int TIMEOUT_CYCLES = 540000,
    localparam int NPIX = IMG_W * IMG_H,
    localparam int AW   = $clog2(NPIX),
    localparam int PW   = 8 * PIXEL_BYTES,
    localparam int BW   = $clog2(PIXEL_BYTES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          uart_data_rdy,
    input  logic [7:0]    uart_data,
    input  logic          img_consumed,
    output logic          pix_we,
    output logic [AW-1:0] pix_addr,
    output logic [PW-1:0] pix_data,
    output logic          img_ready,
    output logic          fpga_can_receive,
    output logic          err_timeout,
    output logic          err_overrun,
    output logic          chk_ok
);

    typedef enum logic [1:0] {S_RECV, S_CHECK, S_FULL} state_t;

    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t        state_q, state_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [AW-1:0] pix_idx_q, pix_idx_d;
    logic [31:0]   idle_cnt_q, idle_cnt_d;
    logic [PW-1:0] shift_q, shift_d;
    logic          pix_we_q, pix_we_d;
    logic [AW-1:0] pix_addr_q, pix_addr_d;
    logic [PW-1:0] pix_data_q, pix_data_d;
    logic          img_ready_q, img_ready_d;
    logic          fcr_q, fcr_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_overrun_q, err_overrun_d;
    logic          mid_frame;
`ifdef UART_IMG_CHECKSUM_EN
    logic          chk_ok_q, chk_ok_d;
    logic [7:0]    sum_q, sum_d;
`endif

    // The checksum wait counts as mid-frame so a lost checksum byte still times out.
    assign mid_frame = (pix_idx_q != '0) || (byte_idx_q != '0) || (state_q == S_CHECK);

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        pix_idx_d     = pix_idx_q;
        idle_cnt_d    = idle_cnt_q;
        shift_d       = shift_q;
        pix_we_d      = 1'b0;
        pix_addr_d    = pix_addr_q;
        pix_data_d    = pix_data_q;
        img_ready_d   = img_ready_q;
        fcr_d         = fcr_q;
        err_timeout_d = 1'b0;
        err_overrun_d = err_overrun_q;
`ifdef UART_IMG_CHECKSUM_EN
        chk_ok_d      = chk_ok_q;
        sum_d         = sum_q;
`endif
        case (state_q)
            S_RECV: begin
                if (uart_data_rdy) begin
                    idle_cnt_d = '0;
                    for (int k = 0; k < PIXEL_BYTES; k++) begin
                        if (byte_idx_q == BW'(k)) shift_d[8*k +: 8] = uart_data;
                    end
`ifdef UART_IMG_CHECKSUM_EN
                    sum_d = mid_frame ? (sum_q + uart_data) : uart_data;
`endif
                    if (byte_idx_q == BW'(PIXEL_BYTES - 1)) begin
                        pix_we_d   = 1'b1;
                        pix_addr_d = pix_idx_q;
                        pix_data_d = shift_d;
                        byte_idx_d = '0;
                        if (pix_idx_q == AW'(NPIX - 1)) begin
                            pix_idx_d = '0;
`ifdef UART_IMG_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            img_ready_d = 1'b1;
                            fcr_d       = 1'b0;
                            state_d     = S_FULL;
`endif
                        end else begin
                            pix_idx_d = pix_idx_q + AW'(1);
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                    end
                end
            end
`ifdef UART_IMG_CHECKSUM_EN
            S_CHECK: begin
                if (uart_data_rdy) begin
                    idle_cnt_d  = '0;
                    chk_ok_d    = (sum_q == uart_data);
                    img_ready_d = 1'b1;
                    fcr_d       = 1'b0;
                    state_d     = S_FULL;
                end
            end
`endif
            S_FULL: begin
                if (img_consumed) begin
                    img_ready_d   = 1'b0;
                    fcr_d         = 1'b1;
                    pix_idx_d     = '0;
                    byte_idx_d    = '0;
                    err_overrun_d = 1'b0;
                    state_d       = S_RECV;
`ifdef UART_IMG_CHECKSUM_EN
                    chk_ok_d      = 1'b0;
`endif
                end else if (uart_data_rdy) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: state_d = S_RECV;
        endcase

        // A strobe in the expiry cycle is handled above and suppresses the abort.
        if (TIMEOUT_CYCLES > 0 && state_q != S_FULL && !uart_data_rdy) begin
            if (!mid_frame) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == TMO_LAST) begin
                pix_idx_d     = '0;
                byte_idx_d    = '0;
                idle_cnt_d    = '0;
                err_timeout_d = 1'b1;
                state_d       = S_RECV;
            end else if (idle_cnt_q != '1) begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_RECV;
            byte_idx_q    <= '0;
            pix_idx_q     <= '0;
            idle_cnt_q    <= '0;
            shift_q       <= '0;
            pix_we_q      <= 1'b0;
            pix_addr_q    <= '0;
            pix_data_q    <= '0;
            img_ready_q   <= 1'b0;
            fcr_q         <= 1'b1;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef UART_IMG_CHECKSUM_EN
            chk_ok_q      <= 1'b0;
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            pix_idx_q     <= pix_idx_d;
            idle_cnt_q    <= idle_cnt_d;
            shift_q       <= shift_d;
            pix_we_q      <= pix_we_d;
            pix_addr_q    <= pix_addr_d;
            pix_data_q    <= pix_data_d;
            img_ready_q   <= img_ready_d;
            fcr_q         <= fcr_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
`ifdef UART_IMG_CHECKSUM_EN
            chk_ok_q      <= chk_ok_d;
            sum_q         <= sum_d;
`endif
        end
    end

    assign pix_we           = pix_we_q;
    assign pix_addr         = pix_addr_q;
    assign pix_data         = pix_data_q;
    assign img_ready        = img_ready_q;
    assign fpga_can_receive = fcr_q;
    assign err_timeout      = err_timeout_q;
    assign err_overrun      = err_overrun_q;
`ifdef UART_IMG_CHECKSUM_EN
    assign chk_ok           = chk_ok_q;
`else
    assign chk_ok           = 1'b1;
`endif

endmodule

// File: tb/tb_uart_image_loader.sv
// Bench for uart_image_loader on a 4x2 image of 2-byte pixels with a 100-cycle idle timeout.
module tb_uart_image_loader;

    localparam int W = 4, H = 2, PB = 2, TMO = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        uart_data_rdy;
    logic [7:0]  uart_data;
    logic        img_consumed;
    logic        pix_we;
    logic [2:0]  pix_addr;
    logic [15:0] pix_data;
    logic        img_ready;
    logic        fpga_can_receive;
    logic        err_timeout;
    logic        err_overrun;
    logic        chk_ok;

    uart_image_loader #(
        .IMG_W(W), .IMG_H(H), .PIXEL_BYTES(PB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .uart_data_rdy(uart_data_rdy), .uart_data(uart_data),
        .img_consumed(img_consumed),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
        .img_ready(img_ready), .fpga_can_receive(fpga_can_receive),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .chk_ok(chk_ok)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  b;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        ready;
        logic        fcr;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[16];
    int   checks = 0, errors = 0;
    int   we_seen = 0, tmo_seen = 0, pushes = 0;
    int   m_idx = 0, m_pix = 0;
    logic [7:0] m_lo = 8'h00;
    logic [7:0] sum = 8'h00;

`ifdef UART_IMG_CHECKSUM_EN
    localparam logic CHK_RESET = 1'b0;
`else
    localparam logic CHK_RESET = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled 1 time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        if (err_timeout === 1'b1) tmo_seen++;
        if (pix_we === 1'b1) begin
            we_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_we_unexpected: got addr %0h data %0h, no write expected", pix_addr, pix_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("pix_addr", 32'(pix_addr), 32'(e.addr));
                check("pix_data", 32'(pix_data), 32'(e.data));
            end
        end
    end

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
        pushes++;
    endtask

    // Called at a falling edge; the byte is captured at the next rising edge.
    task automatic strobe(input logic [7:0] b);
        uart_data_rdy = 1'b1;
        uart_data     = b;
        @(negedge clock);
        uart_data_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        if (m_idx == 1) begin
            push_wr(3'(m_pix), {b, m_lo});
            m_pix++;
            m_idx = 0;
        end else begin
            m_lo  = b;
            m_idx = 1;
        end
        sum = (m_pix == 0 && m_idx == 1) ? b : sum + b;
        strobe(b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_we"}, 32'(pix_we), 0);
        check({tag, "_pix_addr"}, 32'(pix_addr), 0);
        check({tag, "_pix_data"}, 32'(pix_data), 0);
        check({tag, "_img_ready"}, 32'(img_ready), 0);
        check({tag, "_fcr"}, 32'(fpga_can_receive), 1);
        check({tag, "_err_timeout"}, 32'(err_timeout), 0);
        check({tag, "_err_overrun"}, 32'(err_overrun), 0);
        check({tag, "_chk_ok"}, 32'(chk_ok), 32'(CHK_RESET));
    endtask

    initial begin
        int t0, w0;
        logic [7:0] ck;
        reset = 1'b1;
        uart_data_rdy = 1'b0;
        uart_data = 8'h00;
        img_consumed = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].b    = 8'(i + 1);
            tbl[i].we   = (i % 2 == 1);
            tbl[i].addr = 3'(i / 2);
            tbl[i].data = {8'(i + 1), 8'(i)};
`ifdef UART_IMG_CHECKSUM_EN
            tbl[i].ready = 1'b0;
            tbl[i].fcr   = 1'b1;
`else
            tbl[i].ready = (i == 15);
            tbl[i].fcr   = (i != 15);
`endif
        end

        idle(2);
        check_reset_outputs("rst");
        reset = 1'b0;
        idle(2);

        // Frame 0x01..0x10 from the vector table.
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].we) push_wr(tbl[i].addr, tbl[i].data);
            strobe(tbl[i].b);
            check($sformatf("t1_ready_%0d", i), 32'(img_ready), 32'(tbl[i].ready));
            check($sformatf("t1_fcr_%0d", i), 32'(fpga_can_receive), 32'(tbl[i].fcr));
            idle(49);
        end
        check("t1_writes", we_seen, 8);
`ifdef UART_IMG_CHECKSUM_EN
        strobe(8'h88);
        check("t6_chk_ok_good", 32'(chk_ok), 1);
        check("t6_ready", 32'(img_ready), 1);
        check("t6_fcr", 32'(fpga_can_receive), 0);
        idle(2);
        check("t6_no_we_good", we_seen, 8);
`else
        check("t1_chk_ok_tied", 32'(chk_ok), 1);
`endif

        // Overrun while the frame is held, then release.
        w0 = we_seen;
        strobe(8'hAA);
        idle(2);
        check("t2_no_we", we_seen, w0);
        check("t2_overrun", 32'(err_overrun), 1);
        check("t2_ready_held", 32'(img_ready), 1);
        img_consumed = 1'b1;
        @(negedge clock);
        img_consumed = 1'b0;
        check("t2_ready_clr", 32'(img_ready), 0);
        check("t2_fcr_set", 32'(fpga_can_receive), 1);
        check("t2_overrun_clr", 32'(err_overrun), 0);
        check("t2_chk_ok", 32'(chk_ok), 32'(CHK_RESET));
        m_idx = 0;
        m_pix = 0;

        // Five bytes then silence: abort exactly 100 cycles after the last strobe.
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h21 + i));
            if (i < 4) idle(49);
        end
        t0 = tmo_seen;
        idle(98);
        check("t3_no_early_tmo", tmo_seen, t0);
        idle(1);
        check("t3_tmo_low_before", 32'(err_timeout), 0);
        idle(1);
        check("t3_tmo_pulse", 32'(err_timeout), 1);
        idle(1);
        check("t3_tmo_low_after", 32'(err_timeout), 0);
        check("t3_tmo_count", tmo_seen, t0 + 1);
        m_idx = 0;
        m_pix = 0;
        idle(10);

        // Strobe landing in the expiry cycle wins over the timeout.
        t0 = tmo_seen;
        send(8'h31);
        idle(99);
        send(8'h32);
        idle(5);
        check("t4_no_tmo", tmo_seen, t0);
        check("t4_fifo_drained", exp_q.size(), 0);
        idle(44);

        // Reset partway into the next pixels.
        send(8'h41);
        idle(49);
        send(8'h42);
        idle(49);
        send(8'h43);
        idle(10);
        reset = 1'b1;
        idle(1);
        check_reset_outputs("t5_rst");
        reset = 1'b0;
        m_idx = 0;
        m_pix = 0;
        idle(2);
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h51 + i));
            idle(49);
        end
`ifdef UART_IMG_CHECKSUM_EN
        check("t5_wait_chk", 32'(fpga_can_receive), 1);
        ck = sum + 8'd1;
        w0 = we_seen;
        strobe(ck);
        check("t6_chk_ok_bad", 32'(chk_ok), 0);
        check("t6_ready_bad", 32'(img_ready), 1);
        idle(2);
        check("t6_no_we_bad", we_seen, w0);
`else
        ck = sum;
        check("t5_ready", 32'(img_ready), 1);
        check("t5_fcr", 32'(fpga_can_receive), 0);
`endif

        idle(3);
        check("sb_drained", exp_q.size(), 0);
        check("sb_write_count", we_seen, pushes);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
